usb_ep_buf_arb: RTL and testbench
=================================

// Module: usb_ep_buf_arb
// PURPOSE
//  Shares one endpoint buffer (1 read port, 1 write port, 1-cycle registered read) between the
//  USB packet engine and a system-bus requester. USB side has absolute priority and is never
//  stalled; bus accesses are held in a single-entry slot and issued in free port cycles.
//  Sits between the USB transaction core / bus interface and the EP buffer RAM.
// PARAMETERS
//  AWIDTH   11  buffer byte address width
//  DWIDTH   8   data width, both sides (8/16/32); MWIDTH = DWIDTH/8 byte-mask width
// PORTS
//  clk            in   1        single clock, also drives buffer rd_clk/wr_clk
//  rst_n          in   1        asynchronous reset, active low
//  usb_rd_addr    in   AWIDTH   USB read address (cycle N)
//  usb_rd_en      in   1        USB read request, always granted
//  usb_rd_data    out  DWIDTH   USB read data, valid cycle N+1 (buffer output passthrough)
//  usb_wr_addr    in   AWIDTH   USB write address
//  usb_wr_data    in   DWIDTH   USB write data
//  usb_wr_en      in   1        USB write request, always granted, full mask
//  bus_addr       in   AWIDTH   bus request address
//  bus_wdata      in   DWIDTH   bus write data
//  bus_wmask      in   MWIDTH   bus byte-enable (writes only)
//  bus_we         in   1        1 = write, 0 = read
//  bus_valid      in   1        bus request valid
//  bus_ready      out  1        slot empty; request accepted when valid & ready
//  bus_rdata      out  DWIDTH   registered bus read data, held until next bus read completes
//  bus_rvalid     out  1        1-cycle pulse: bus_rdata updated
//  buf_rd_addr_0/buf_rd_en_0/buf_rd_data_1   buffer read port (out/out/in)
//  buf_wr_addr_0/buf_wr_data_0/buf_wr_mask_0/buf_wr_en_0   buffer write port (out)
// BEHAVIOUR
//  Reset: slot empty, bus_ready=1, bus_rvalid=0, bus_rdata=0, rd-issued flag 0, counter 0.
//  Slot FSM: EMPTY -> FULL on valid&ready (captured cycle N); FULL -> EMPTY in cycle it issues.
//   bus_ready = (state==EMPTY), registered; never accepts and issues in the same cycle.
//  Issue rule (from FULL, earliest N+1): read issues when usb_rd_en=0; write issues when
//   usb_wr_en=0. Read and write ports arbitrated independently: bus write may issue in the
//   same cycle as a USB read and vice versa.
//  Port mux: buf_*_en_0 = usb_*_en | bus issue; USB fields win when usb en set. USB writes use
//   mask all-ones; bus writes use bus_wmask.
//  Bus read return: issue cycle M -> buf_rd_data_1 captured into bus_rdata at edge ending M+1,
//   bus_rvalid high cycle M+2 for exactly one cycle. Bus read latency from accept: >=3 cycles.
//  usb_rd_data is buf_rd_data_1 unregistered; content only meaningful cycle after usb_rd_en.
//  Same-address hazard: no forwarding; read in same cycle as write to same address returns old
//   data (RAM behaviour). Ordering within bus side preserved (single slot).
//  Starvation: bus waits indefinitely while USB holds the needed port every cycle; no drop.
//  Reset asserted mid-operation: pending slot discarded, no rvalid pulse, enables deassert
//   immediately (asynchronous), bus_ready=1 after release.
// CONFIGURATION
//  USB_EP_BUF_ARB_STATS_EN defined: adds output stat_defer [15:0]; increments each cycle the
//   slot is FULL and not issued due to USB priority; saturates at 16'hFFFF; cleared by reset
//   and by input stat_clr (1 cycle pulse, clear wins over increment).
//  Undefined: stat_defer and stat_clr ports absent, no counter logic.
// TESTING
//  Bus write 0x5A @0x010, USB idle -> ready low 1 cycle, buf_wr_en_0 pulse next cycle, mask=1s.
//  Bus read @0x010 after above, USB idle -> bus_rvalid pulse 3 cycles after accept, rdata=0x5A.
//  USB reads every cycle for 10 cycles with bus read pending -> bus issue on cycle 11,
//   usb_rd_data correct throughout; STATS_EN: stat_defer=10.
//  USB write and bus read same cycle, different addrs -> both issue same cycle, no deferral.
//  USB write 0xA5 @0x020 same cycle bus write 0x11 pending @0x020 -> USB first, bus next
//   cycle; final readback 0x11.
//  rst_n low while slot FULL (read) -> no rvalid, bus_ready=1 after release, counter 0.

Source files
------------

// File: rtl/usb_ep_buf_arb_if.sv
// System-bus request channel into the endpoint-buffer arbiter: single request slot
// handshake (valid/ready) plus registered read return (rdata/rvalid).
interface usb_ep_buf_arb_if #(
    parameter int AWIDTH = 11,
    parameter int DWIDTH = 8
);
    localparam int MWIDTH = DWIDTH / 8;

    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata;
    logic [MWIDTH-1:0] wmask;
    logic              we;
    logic              valid;
    logic              ready;
    logic [DWIDTH-1:0] rdata;
    logic              rvalid;

    modport master (
        output addr, wdata, wmask, we, valid,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  addr, wdata, wmask, we, valid,
        output ready, rdata, rvalid
    );
endinterface

// File: rtl/usb_ep_buf_arb.sv
// Endpoint-buffer port arbiter: USB side always granted, bus side parked in one slot and
// issued in free port cycles. Optional deferral counter enabled by USB_EP_BUF_ARB_STATS_EN.
module usb_ep_buf_arb #(
    parameter int AWIDTH = 11,
    parameter int DWIDTH = 8,
    localparam int MWIDTH = DWIDTH / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWIDTH-1:0] usb_rd_addr,
    input  logic              usb_rd_en,
    output logic [DWIDTH-1:0] usb_rd_data,
    input  logic [AWIDTH-1:0] usb_wr_addr,
    input  logic [DWIDTH-1:0] usb_wr_data,
    input  logic              usb_wr_en,
    usb_ep_buf_arb_if.slave   bus,
    output logic [AWIDTH-1:0] buf_rd_addr_0,
    output logic              buf_rd_en_0,
    input  logic [DWIDTH-1:0] buf_rd_data_1,
    output logic [AWIDTH-1:0] buf_wr_addr_0,
    output logic [DWIDTH-1:0] buf_wr_data_0,
    output logic [MWIDTH-1:0] buf_wr_mask_0,
    output logic              buf_wr_en_0
`ifdef USB_EP_BUF_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_defer
`endif
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]        state;
    logic [AWIDTH-1:0] slot_addr;
    logic [DWIDTH-1:0] slot_wdata;
    logic [MWIDTH-1:0] slot_wmask;
    logic              slot_we;

    logic              accept;
    logic              issue_rd;
    logic              issue_wr;
    logic              issue;

    logic              rd_issued_p1;
    logic              rvalid_p2;
    logic [DWIDTH-1:0] rdata_p2;

    // Accept only from EMPTY, issue only from FULL: the two never coincide.
    assign accept   = (state == ST_EMPTY) && bus.valid;
    assign issue_rd = (state == ST_FULL) && !slot_we && !usb_rd_en;
    assign issue_wr = (state == ST_FULL) &&  slot_we && !usb_wr_en;
    assign issue    = issue_rd | issue_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else if (accept) begin
            state <= ST_FULL;
        end else if (issue) begin
            state <= ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            slot_addr  <= bus.addr;
            slot_wdata <= bus.wdata;
            slot_wmask <= bus.wmask;
            slot_we    <= bus.we;
        end
    end

    assign bus.ready = (state == ST_EMPTY);

    // Enables are gated by rst_n so the buffer sees no access while reset is held.
    assign buf_rd_en_0   = rst_n & (usb_rd_en | issue_rd);
    assign buf_rd_addr_0 = usb_rd_en ? usb_rd_addr : slot_addr;

    assign buf_wr_en_0   = rst_n & (usb_wr_en | issue_wr);
    assign buf_wr_addr_0 = usb_wr_en ? usb_wr_addr : slot_addr;
    assign buf_wr_data_0 = usb_wr_en ? usb_wr_data : slot_wdata;
    assign buf_wr_mask_0 = usb_wr_en ? {MWIDTH{1'b1}} : slot_wmask;

    assign usb_rd_data = buf_rd_data_1;

    // p1: buffer read in flight; p2: bus read data captured and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_issued_p1 <= 1'b0;
            rvalid_p2    <= 1'b0;
            rdata_p2     <= '0;
        end else begin
            rd_issued_p1 <= issue_rd;
            rvalid_p2    <= rd_issued_p1;
            if (rd_issued_p1) begin
                rdata_p2 <= buf_rd_data_1;
            end
        end
    end

    assign bus.rdata  = rdata_p2;
    assign bus.rvalid = rvalid_p2;

`ifdef USB_EP_BUF_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic defer;
    // A full slot that does not issue is always blocked by the USB side.
    assign defer = (state == ST_FULL) && !issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_defer <= '0;
        end else if (stat_clr) begin
            stat_defer <= '0;
        end else if (defer) begin
            stat_defer <= sat_inc(stat_defer);
        end
    end
`endif

endmodule

// File: tb/tb_usb_ep_buf_arb.sv
// Self-checking bench for usb_ep_buf_arb: directed scenarios plus randomized traffic checked
// against a shadow-memory / due-time reference model of the arbitration rules.
module tb_usb_ep_buf_arb;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int MW = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_req = 1'b1;
    logic [AW-1:0] usb_rd_addr;
    logic          usb_rd_en;
    logic [DW-1:0] usb_rd_data;
    logic [AW-1:0] usb_wr_addr;
    logic [DW-1:0] usb_wr_data;
    logic          usb_wr_en;
    logic [AW-1:0] buf_rd_addr_0;
    logic          buf_rd_en_0;
    logic [DW-1:0] buf_rd_data_1 = '0;
    logic [AW-1:0] buf_wr_addr_0;
    logic [DW-1:0] buf_wr_data_0;
    logic [MW-1:0] buf_wr_mask_0;
    logic          buf_wr_en_0;
    logic          stat_clr;
    logic [15:0]   stat_defer;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    usb_ep_buf_arb_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    usb_ep_buf_arb #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .usb_rd_addr(usb_rd_addr), .usb_rd_en(usb_rd_en), .usb_rd_data(usb_rd_data),
        .usb_wr_addr(usb_wr_addr), .usb_wr_data(usb_wr_data), .usb_wr_en(usb_wr_en),
        .bus(bus),
        .buf_rd_addr_0(buf_rd_addr_0), .buf_rd_en_0(buf_rd_en_0), .buf_rd_data_1(buf_rd_data_1),
        .buf_wr_addr_0(buf_wr_addr_0), .buf_wr_data_0(buf_wr_data_0),
        .buf_wr_mask_0(buf_wr_mask_0), .buf_wr_en_0(buf_wr_en_0)
`ifdef USB_EP_BUF_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_defer(stat_defer)
`endif
    );

`ifndef USB_EP_BUF_ARB_STATS_EN
    assign stat_defer = '0;
`endif

    function automatic logic [DW-1:0] pat(input int i);
        return DW'(i * 7 + 1);
    endfunction

    // Buffer RAM: 1-cycle registered read, byte-masked write, read-before-write.
    logic [DW-1:0] ram [0:DEPTH-1];
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= pat(i);
        end else begin
            if (buf_rd_en_0) buf_rd_data_1 <= ram[buf_rd_addr_0];
            if (buf_wr_en_0)
                for (int b = 0; b < MW; b++)
                    if (buf_wr_mask_0[b]) ram[buf_wr_addr_0][b*8 +: 8] <= buf_wr_data_0[b*8 +: 8];
        end
    end

    // Reference model: shadow memory, one pending bus request, read returns scheduled by due cycle.
    typedef struct { int due; logic [DW-1:0] d; } rv_ev_t;
    rv_ev_t        rv_q[$];
    logic [DW-1:0] shadow [0:DEPTH-1];
    logic          m_pend = 1'b0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [MW-1:0] m_wmask = '0;
    logic          m_rv = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_usb_vld = 1'b0;
    logic [DW-1:0] m_usb_data = '0;
    int            m_defer = 0;
    int            cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        logic          m_issue;
        logic [DW-1:0] merged;
        if (!rst_n) begin
            m_pend <= 1'b0; m_rv <= 1'b0; m_rdata <= '0; m_usb_vld <= 1'b0; m_defer <= 0;
            rv_q.delete();
            if (init_req) for (int i = 0; i < DEPTH; i++) shadow[i] <= pat(i);
        end else begin
            m_issue = m_pend && (m_we ? !usb_wr_en : !usb_rd_en);
            if (rv_q.size() > 0 && rv_q[0].due == cyc + 1) begin
                m_rv <= 1'b1; m_rdata <= rv_q[0].d; void'(rv_q.pop_front());
            end else begin
                m_rv <= 1'b0;
            end
            if (m_issue && !m_we) rv_q.push_back('{cyc + 2, shadow[m_addr]});
            m_usb_vld  <= usb_rd_en;
            m_usb_data <= shadow[usb_rd_addr];
            if (usb_wr_en) begin
                shadow[usb_wr_addr] <= usb_wr_data;
            end else if (m_issue && m_we) begin
                merged = shadow[m_addr];
                for (int b = 0; b < MW; b++) if (m_wmask[b]) merged[b*8 +: 8] = m_wdata[b*8 +: 8];
                shadow[m_addr] <= merged;
            end
            if (m_pend && !m_issue && m_defer < 65535) m_defer <= m_defer + 1;
            if (stat_clr) m_defer <= 0;
            if (!m_pend && bus.valid) begin
                m_pend <= 1'b1; m_we <= bus.we; m_addr <= bus.addr;
                m_wdata <= bus.wdata; m_wmask <= bus.wmask;
            end else if (m_issue) begin
                m_pend <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        usb_rd_en = 1'b0; usb_rd_addr = '0; usb_wr_en = 1'b0; usb_wr_addr = '0; usb_wr_data = '0;
        bus.valid = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wmask = '0;
        stat_clr = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0; init_req = 1'b1;
        repeat (2) @(posedge clk);
        #1 init_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (buf_rd_en_0 !== 1'b0 || buf_wr_en_0 !== 1'b0) begin n_fail++; $display("FAIL rst_enables: got rd=%0b wr=%0b want 0/0", buf_rd_en_0, buf_wr_en_0); end
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", bus.ready); end
        n_cmp++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %0b want 0", bus.rvalid); end
        n_cmp++; if (bus.rdata !== '0) begin n_fail++; $display("FAIL rst_rdata: got %0h want 0", bus.rdata); end
        n_cmp++; if (stat_defer !== 16'd0) begin n_fail++; $display("FAIL rst_stat: got %0d want 0", stat_defer); end
        tick();
    endtask

    task automatic test_bus_write();
        bus.valid = 1'b1; bus.we = 1'b1; bus.addr = 11'h010; bus.wdata = 16'h005A; bus.wmask = 2'b11;
        @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b1 || buf_wr_en_0 !== 1'b0) begin n_fail++; $display("FAIL bw_accept: got ready=%0b wr_en=%0b want 1/0", bus.ready, buf_wr_en_0); end
        tick();
        bus.valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL bw_ready_low: got %0b want 0", bus.ready); end
        n_cmp++; if (buf_wr_en_0 !== 1'b1 || buf_wr_addr_0 !== 11'h010) begin n_fail++; $display("FAIL bw_issue: got en=%0b addr=%0h want 1/010", buf_wr_en_0, buf_wr_addr_0); end
        n_cmp++; if (buf_wr_data_0 !== 16'h005A || buf_wr_mask_0 !== 2'b11) begin n_fail++; $display("FAIL bw_data: got %0h/%0b want 005a/11", buf_wr_data_0, buf_wr_mask_0); end
        tick();
        @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b1 || buf_wr_en_0 !== 1'b0) begin n_fail++; $display("FAIL bw_done: got ready=%0b wr_en=%0b want 1/0", bus.ready, buf_wr_en_0); end
        tick();
    endtask

    task automatic test_bus_read();
        bus.valid = 1'b1; bus.we = 1'b0; bus.addr = 11'h010;
        tick();
        bus.valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (buf_rd_en_0 !== 1'b1 || buf_rd_addr_0 !== 11'h010) begin n_fail++; $display("FAIL br_issue: got en=%0b addr=%0h want 1/010", buf_rd_en_0, buf_rd_addr_0); end
        n_cmp++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL br_rvalid_c1: got %0b want 0", bus.rvalid); end
        tick();
        @(negedge clk);
        n_cmp++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL br_rvalid_c2: got %0b want 0", bus.rvalid); end
        tick();
        @(negedge clk);
        n_cmp++; if (bus.rvalid !== 1'b1 || bus.rdata !== 16'h005A) begin n_fail++; $display("FAIL br_return: got rvalid=%0b rdata=%0h want 1/005a", bus.rvalid, bus.rdata); end
        tick();
        @(negedge clk);
        n_cmp++; if (bus.rvalid !== 1'b0 || bus.rdata !== 16'h005A) begin n_fail++; $display("FAIL br_hold: got rvalid=%0b rdata=%0h want 0/005a", bus.rvalid, bus.rdata); end
        tick();
    endtask

    task automatic test_usb_starve();
        logic [AW-1:0] a;
        bus.valid = 1'b1; bus.we = 1'b0; bus.addr = 11'h030; stat_clr = 1'b1;
        tick();
        bus.valid = 1'b0; stat_clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a = 11'h100 + AW'(i);
            usb_rd_en = 1'b1; usb_rd_addr = a;
            @(negedge clk);
            n_cmp++; if (bus.ready !== 1'b0 || buf_rd_en_0 !== 1'b1 || buf_rd_addr_0 !== a) begin n_fail++; $display("FAIL starve_usb_owns_%0d: got ready=%0b en=%0b addr=%0h want 0/1/%0h", i, bus.ready, buf_rd_en_0, buf_rd_addr_0, a); end
            if (i > 0) begin
                n_cmp++; if (usb_rd_data !== pat(32'h100 + i - 1)) begin n_fail++; $display("FAIL starve_usb_data_%0d: got %0h want %0h", i, usb_rd_data, pat(32'h100 + i - 1)); end
            end
            tick();
        end
        usb_rd_en = 1'b0;
        @(negedge clk);
        n_cmp++; if (buf_rd_en_0 !== 1'b1 || buf_rd_addr_0 !== 11'h030) begin n_fail++; $display("FAIL starve_issue: got en=%0b addr=%0h want 1/030", buf_rd_en_0, buf_rd_addr_0); end
        n_cmp++; if (usb_rd_data !== pat(32'h109)) begin n_fail++; $display("FAIL starve_usb_last: got %0h want %0h", usb_rd_data, pat(32'h109)); end
        tick();
        @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL starve_ready: got %0b want 1", bus.ready); end
`ifdef USB_EP_BUF_ARB_STATS_EN
        n_cmp++; if (stat_defer !== 16'd10) begin n_fail++; $display("FAIL starve_stat: got %0d want 10", stat_defer); end
`endif
        tick();
        @(negedge clk);
        n_cmp++; if (bus.rvalid !== 1'b1 || bus.rdata !== pat(32'h030)) begin n_fail++; $display("FAIL starve_return: got rvalid=%0b rdata=%0h want 1/%0h", bus.rvalid, bus.rdata, pat(32'h030)); end
        tick();
    endtask

    task automatic test_usb_wr_bus_rd();
        bus.valid = 1'b1; bus.we = 1'b0; bus.addr = 11'h040;
        tick();
        bus.valid = 1'b0;
        usb_wr_en = 1'b1; usb_wr_addr = 11'h050; usb_wr_data = 16'h7777;
        @(negedge clk);
        n_cmp++; if (buf_rd_en_0 !== 1'b1 || buf_rd_addr_0 !== 11'h040) begin n_fail++; $display("FAIL par_rd: got en=%0b addr=%0h want 1/040", buf_rd_en_0, buf_rd_addr_0); end
        n_cmp++; if (buf_wr_en_0 !== 1'b1 || buf_wr_addr_0 !== 11'h050 || buf_wr_data_0 !== 16'h7777 || buf_wr_mask_0 !== 2'b11) begin n_fail++; $display("FAIL par_wr: got en=%0b addr=%0h data=%0h mask=%0b want 1/050/7777/11", buf_wr_en_0, buf_wr_addr_0, buf_wr_data_0, buf_wr_mask_0); end
        tick();
        usb_wr_en = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL par_ready: got %0b want 1", bus.ready); end
`ifdef USB_EP_BUF_ARB_STATS_EN
        n_cmp++; if (stat_defer !== 16'd10) begin n_fail++; $display("FAIL par_stat: got %0d want 10", stat_defer); end
`endif
        tick();
        @(negedge clk);
        n_cmp++; if (bus.rvalid !== 1'b1 || bus.rdata !== pat(32'h040)) begin n_fail++; $display("FAIL par_return: got rvalid=%0b rdata=%0h want 1/%0h", bus.rvalid, bus.rdata, pat(32'h040)); end
        tick();
    endtask

    task automatic test_same_addr();
        bus.valid = 1'b1; bus.we = 1'b1; bus.addr = 11'h020; bus.wdata = 16'h0011; bus.wmask = 2'b11;
        tick();
        bus.valid = 1'b0;
        usb_wr_en = 1'b1; usb_wr_addr = 11'h020; usb_wr_data = 16'h00A5;
        @(negedge clk);
        n_cmp++; if (buf_wr_en_0 !== 1'b1 || buf_wr_data_0 !== 16'h00A5 || bus.ready !== 1'b0) begin n_fail++; $display("FAIL same_usb_first: got en=%0b data=%0h ready=%0b want 1/00a5/0", buf_wr_en_0, buf_wr_data_0, bus.ready); end
        tick();
        usb_wr_en = 1'b0;
        @(negedge clk);
        n_cmp++; if (buf_wr_en_0 !== 1'b1 || buf_wr_addr_0 !== 11'h020 || buf_wr_data_0 !== 16'h0011) begin n_fail++; $display("FAIL same_bus_next: got en=%0b addr=%0h data=%0h want 1/020/0011", buf_wr_en_0, buf_wr_addr_0, buf_wr_data_0); end
        tick();
        bus.valid = 1'b1; bus.we = 1'b0; bus.addr = 11'h020;
        usb_rd_en = 1'b1; usb_rd_addr = 11'h020;
        @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL same_ready: got %0b want 1", bus.ready); end
        tick();
        bus.valid = 1'b0; usb_rd_en = 1'b0;
        @(negedge clk);
        n_cmp++; if (usb_rd_data !== 16'h0011) begin n_fail++; $display("FAIL same_usb_read: got %0h want 0011", usb_rd_data); end
        repeat (2) tick();
        @(negedge clk);
        n_cmp++; if (bus.rvalid !== 1'b1 || bus.rdata !== 16'h0011) begin n_fail++; $display("FAIL same_readback: got rvalid=%0b rdata=%0h want 1/0011", bus.rvalid, bus.rdata); end
        tick();
    endtask

    task automatic test_random();
        int heavy;
        logic exp_rd_en, exp_wr_en;
        for (int c = 0; c < 400; c++) begin
            heavy = (c >= 150 && c < 250) ? 9 : 4;
            usb_rd_en   = ($urandom_range(0, 9) < heavy);
            usb_rd_addr = AW'($urandom_range(0, 15));
            usb_wr_en   = ($urandom_range(0, 9) < heavy);
            usb_wr_addr = AW'($urandom_range(0, 15));
            usb_wr_data = DW'($urandom);
            bus.valid   = ($urandom_range(0, 2) != 0);
            bus.we      = $urandom_range(0, 1) != 0;
            bus.addr    = AW'($urandom_range(0, 15));
            bus.wdata   = DW'($urandom);
            bus.wmask   = MW'($urandom);
            stat_clr    = ($urandom_range(0, 29) == 0);
            @(negedge clk);
            exp_rd_en = usb_rd_en | (m_pend & !m_we & !usb_rd_en);
            exp_wr_en = usb_wr_en | (m_pend &  m_we & !usb_wr_en);
            n_cmp++; if (bus.ready !== !m_pend) begin n_fail++; $display("FAIL rnd_ready@%0d: got %0b want %0b", c, bus.ready, !m_pend); end
            n_cmp++; if (bus.rvalid !== m_rv) begin n_fail++; $display("FAIL rnd_rvalid@%0d: got %0b want %0b", c, bus.rvalid, m_rv); end
            n_cmp++; if (bus.rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata@%0d: got %0h want %0h", c, bus.rdata, m_rdata); end
            n_cmp++; if (buf_rd_en_0 !== exp_rd_en || buf_wr_en_0 !== exp_wr_en) begin n_fail++; $display("FAIL rnd_enables@%0d: got rd=%0b wr=%0b want %0b/%0b", c, buf_rd_en_0, buf_wr_en_0, exp_rd_en, exp_wr_en); end
            if (m_usb_vld) begin
                n_cmp++; if (usb_rd_data !== m_usb_data) begin n_fail++; $display("FAIL rnd_usb_data@%0d: got %0h want %0h", c, usb_rd_data, m_usb_data); end
            end
`ifdef USB_EP_BUF_ARB_STATS_EN
            n_cmp++; if (stat_defer !== 16'(m_defer)) begin n_fail++; $display("FAIL rnd_stat@%0d: got %0d want %0d", c, stat_defer, m_defer); end
`endif
            tick();
        end
        drive_idle();
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        bus.valid = 1'b1; bus.we = 1'b0; bus.addr = 11'h060;
        tick();
        bus.valid = 1'b0;
        usb_rd_en = 1'b1; usb_rd_addr = 11'h000;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (buf_rd_en_0 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_en: got %0b want 0", buf_rd_en_0); end
        n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %0b want 1", bus.ready); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        usb_rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            n_cmp++; if (bus.rvalid !== 1'b0 || bus.ready !== 1'b1 || buf_rd_en_0 !== 1'b0) begin n_fail++; $display("FAIL mid_after_%0d: got rvalid=%0b ready=%0b rd_en=%0b want 0/1/0", i, bus.rvalid, bus.ready, buf_rd_en_0); end
            n_cmp++; if (stat_defer !== 16'd0) begin n_fail++; $display("FAIL mid_stat_%0d: got %0d want 0", i, stat_defer); end
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bus_write();
        test_bus_read();
        test_usb_starve();
        test_usb_wr_bus_rd();
        test_same_addr();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
